// File: rtl/i_cache_refill_ctrl.sv
// I-cache refill controller: on a miss, closes the window, streams CACHE_WORDS words
// from memory into the slice, then reopens base/bound. Optional macro: CRITICAL_WORD_FIRST_EN.
module i_cache_refill_ctrl #(
    parameter int CACHE_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cache_miss,
    input  logic [31:0] miss_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        refill_enable,
    output logic [31:0] refill_address,
    output logic [31:0] refill_data,
    output logic [31:0] set_base_addr,
    output logic [31:0] set_bound_addr,
    output logic        base_addr_we,
    output logic        bound_addr_we,
    output logic        busy,
    output logic        refill_done
);

    localparam int              IW        = $clog2(CACHE_WORDS);
    localparam logic [31:0]     WIN_BYTES = 32'(CACHE_WORDS * 4);
    localparam logic [31:0]     WIN_MASK  = WIN_BYTES - 32'd1;
    localparam logic [IW-1:0]   LAST_CNT  = IW'(CACHE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INVAL = 3'd1,
        S_REQ   = 3'd2,
        S_RESP  = 3'd3,
        S_WRITE = 3'd4,
        S_BOUND = 3'd5,
        S_BASE  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] w_cnt_nxt;
    logic [31:0]   r_win_base;
    logic [31:0]   w_win_base_nxt;
    logic [IW-1:0] w_start_idx;

    logic          r_mem_req_valid;
    logic [31:0]   r_mem_req_addr;
    logic          r_refill_enable;
    logic [31:0]   r_refill_address;
    logic [31:0]   r_refill_data;
    logic [31:0]   r_set_base_addr;
    logic [31:0]   r_set_bound_addr;
    logic          r_base_addr_we;
    logic          r_bound_addr_we;
    logic          r_busy;
    logic          r_refill_done;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start_idx = miss_addr[IW+1:2];
`else
    assign w_start_idx = {IW{1'b0}};
`endif

    // State, index, word count and window base registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= {IW{1'b0}};
            r_cnt      <= {IW{1'b0}};
            r_win_base <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_win_base <= w_win_base_nxt;
        end
    end

    // Next-state logic; r_cnt counts words written independently of the (possibly rotated) index
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_win_base_nxt = r_win_base;
        case (r_state)
            S_IDLE: begin
                if (i_cache_miss) begin
                    w_win_base_nxt = miss_addr & ~WIN_MASK;
                    w_idx_nxt      = w_start_idx;
                    w_cnt_nxt      = {IW{1'b0}};
                    w_state_nxt    = S_INVAL;
                end else begin
                    w_state_nxt    = S_IDLE;
                end
            end
            S_INVAL: w_state_nxt = S_REQ;
            S_REQ: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WRITE: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_BOUND;
                end else begin
                    w_idx_nxt   = r_idx + {{(IW-1){1'b0}}, 1'b1};
                    w_cnt_nxt   = r_cnt + {{(IW-1){1'b0}}, 1'b1};
                    w_state_nxt = S_REQ;
                end
            end
            S_BOUND: w_state_nxt = S_BASE;
            S_BASE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory request and slice write outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req_valid  <= 1'b0;
            r_mem_req_addr   <= 32'd0;
            r_refill_enable  <= 1'b0;
            r_refill_address <= 32'd0;
            r_refill_data    <= 32'd0;
        end else begin
            r_mem_req_valid <= (w_state_nxt == S_REQ);
            r_refill_enable <= (w_state_nxt == S_WRITE);
            if (w_state_nxt == S_REQ) begin
                r_mem_req_addr <= w_win_base_nxt + {{(30-IW){1'b0}}, w_idx_nxt, 2'b00};
            end
            // WRITE is only entered from RESP on mem_rsp_valid, so this captures the response
            if (w_state_nxt == S_WRITE) begin
                r_refill_address <= {{(32-IW){1'b0}}, w_idx_nxt};
                r_refill_data    <= mem_rsp_data;
            end
        end
    end

    // Window programming and status outputs; base and bound strobes come from disjoint states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set_base_addr  <= 32'd0;
            r_set_bound_addr <= 32'd0;
            r_base_addr_we   <= 1'b0;
            r_bound_addr_we  <= 1'b0;
            r_busy           <= 1'b0;
            r_refill_done    <= 1'b0;
        end else begin
            r_base_addr_we  <= (w_state_nxt == S_INVAL) || (w_state_nxt == S_BASE);
            r_bound_addr_we <= (w_state_nxt == S_BOUND);
            r_busy          <= (w_state_nxt != S_IDLE);
            r_refill_done   <= (w_state_nxt == S_BASE);
            if (w_state_nxt == S_INVAL) begin
                r_set_base_addr <= 32'hFFFF_FFFF;
            end else if (w_state_nxt == S_BASE) begin
                r_set_base_addr <= r_win_base;
            end
            if (w_state_nxt == S_BOUND) begin
                r_set_bound_addr <= r_win_base + WIN_BYTES - 32'd4;
            end
        end
    end

    assign mem_req_valid  = r_mem_req_valid;
    assign mem_req_addr   = r_mem_req_addr;
    assign refill_enable  = r_refill_enable;
    assign refill_address = r_refill_address;
    assign refill_data    = r_refill_data;
    assign set_base_addr  = r_set_base_addr;
    assign set_bound_addr = r_set_bound_addr;
    assign base_addr_we   = r_base_addr_we;
    assign bound_addr_we  = r_bound_addr_we;
    assign busy           = r_busy;
    assign refill_done    = r_refill_done;

endmodule

// File: tb/tb_i_cache_refill_ctrl.sv
// Scoreboard bench for i_cache_refill_ctrl (CACHE_WORDS=256); honours CRITICAL_WORD_FIRST_EN.
module tb_i_cache_refill_ctrl;

    localparam int          CW  = 256;
    localparam logic [31:0] WIN = 32'(CW * 4);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cache_miss;
    logic [31:0] miss_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        refill_enable;
    logic [31:0] refill_address;
    logic [31:0] refill_data;
    logic [31:0] set_base_addr;
    logic [31:0] set_bound_addr;
    logic        base_addr_we;
    logic        bound_addr_we;
    logic        busy;
    logic        refill_done;

    logic [165:0] outs;
    assign outs = {mem_req_valid, mem_req_addr, refill_enable, refill_address, refill_data,
                   set_base_addr, set_bound_addr, base_addr_we, bound_addr_we, busy, refill_done};

    i_cache_refill_ctrl #(.CACHE_WORDS(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_cache_miss(i_cache_miss), .miss_addr(miss_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .refill_enable(refill_enable), .refill_address(refill_address), .refill_data(refill_data),
        .set_base_addr(set_base_addr), .set_bound_addr(set_bound_addr),
        .base_addr_we(base_addr_we), .bound_addr_we(bound_addr_we),
        .busy(busy), .refill_done(refill_done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_bound_q[$];
    logic [31:0] exp_base_q[$];
    bit          pend;
    logic [31:0] pend_addr;
    int          wait_c;
    bit          rand_delay;
    logic [31:0] stall_addr;
    int          stall_left;

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected event stream of one refill
    function automatic void push_refill(input logic [31:0] a);
        logic [31:0] base;
        logic [7:0]  st;
        logic [7:0]  ix;
        base = a & ~(WIN - 32'd1);
`ifdef CRITICAL_WORD_FIRST_EN
        st = a[9:2];
`else
        st = 8'd0;
`endif
        exp_base_q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < CW; i++) begin
            ix = st + 8'(i);
            exp_req_q.push_back(base + {22'd0, ix, 2'b00});
            exp_wa_q.push_back({24'd0, ix});
            exp_wd_q.push_back(base + {22'd0, ix, 2'b00});
        end
        exp_bound_q.push_back(base + WIN - 32'd4);
        exp_base_q.push_back(base);
    endfunction

    // Memory model (data = address) and output monitor
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (pend) begin
                if (wait_c == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pend_addr;
                    pend          = 1'b0;
                end else begin
                    wait_c--;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid && !pend && !mem_rsp_valid) begin
                chk("req_expected", exp_req_q.size() != 0, 1'b1);
                if (exp_req_q.size() != 0) begin
                    if (stall_left > 0 && exp_req_q[0] == stall_addr) begin
                        chk("stall_req_addr", mem_req_addr, exp_req_q[0]);
                        stall_left--;
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = 32'hDEAD_BEEF;
                    end else begin
                        chk("mem_req_addr", mem_req_addr, exp_req_q.pop_front());
                        mem_req_ready = 1'b1;
                        pend          = 1'b1;
                        pend_addr     = mem_req_addr;
                        wait_c        = rand_delay ? int'($urandom_range(0, 3)) : 0;
                    end
                end
            end
            if (refill_enable) begin
                chk("wr_expected", exp_wa_q.size() != 0, 1'b1);
                if (exp_wa_q.size() != 0) begin
                    chk("refill_address", refill_address, exp_wa_q.pop_front());
                    chk("refill_data", refill_data, exp_wd_q.pop_front());
                end
            end
            if (bound_addr_we) begin
                chk("bound_expected", exp_bound_q.size() != 0, 1'b1);
                if (exp_bound_q.size() != 0) begin
                    chk("set_bound_addr", set_bound_addr, exp_bound_q.pop_front());
                end
                chk("we_exclusive", base_addr_we, 1'b0);
            end
            if (base_addr_we) begin
                chk("base_expected", exp_base_q.size() != 0, 1'b1);
                if (exp_base_q.size() != 0) begin
                    logic [31:0] eb;
                    eb = exp_base_q.pop_front();
                    chk("set_base_addr", set_base_addr, eb);
                    chk("refill_done", refill_done, eb != 32'hFFFF_FFFF);
                end
            end else if (refill_done) begin
                chk("done_without_base", refill_done, 1'b0);
            end
        end
    end

    task automatic wait_done(input int start, output int cyc, output bit seen);
        cyc  = start;
        seen = refill_done;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            seen = refill_done;
        end
    endtask

    task automatic run_refill(input logic [31:0] a, input bit chk_lat);
        int cyc;
        bit seen;
        push_refill(a);
        @(negedge clk);
        i_cache_miss = 1'b1;
        miss_addr    = a;
        @(negedge clk);
        i_cache_miss = 1'b0;
        wait_done(1, cyc, seen);
        chk("done_seen", seen, 1'b1);
        if (chk_lat) chk("latency", cyc, 1 + 3 * CW + 2);
        @(negedge clk);
        chk("idle_strobes", {mem_req_valid, refill_enable, base_addr_we, bound_addr_we, busy, refill_done}, 6'd0);
        chk("base_held", set_base_addr, a & ~(WIN - 32'd1));
        chk("bound_held", set_bound_addr, (a & ~(WIN - 32'd1)) + WIN - 32'd4);
        chk("queues_empty", exp_req_q.size() + exp_wa_q.size() + exp_bound_q.size() + exp_base_q.size(), 0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst_n        = 1'b0;
        i_cache_miss = 1'b0;
        miss_addr    = 32'd0;
        pend         = 1'b0;
        pend_addr    = 32'd0;
        wait_c       = 0;
        rand_delay   = 1'b0;
        stall_addr   = 32'd0;
        stall_left   = 0;
        #2;
        chk("reset_outputs", outs, 166'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", outs, 166'd0);

        run_refill(32'h0000_1234, 1'b1);

        // Word 3 stalled 5 cycles, random response delays
        rand_delay = 1'b1;
        stall_addr = 32'h0000_100C;
        stall_left = 5;
        run_refill(32'h0000_1234, 1'b0);
        rand_delay = 1'b0;
        chk("stall_consumed", stall_left, 0);

        // Miss during refill is ignored; still held after done it starts the next refill
        push_refill(32'h0000_1234);
        @(negedge clk);
        i_cache_miss = 1'b1;
        miss_addr    = 32'h0000_1234;
        @(negedge clk);
        i_cache_miss = 1'b0;
        repeat (50) @(negedge clk);
        push_refill(32'h0000_2000);
        i_cache_miss = 1'b1;
        miss_addr    = 32'h0000_2000;
        wait_done(51, cyc, seen);
        chk("first_done_seen", seen, 1'b1);
        @(negedge clk);
        chk("idle_between", busy, 1'b0);
        @(negedge clk);
        chk("restart_busy", busy, 1'b1);
        i_cache_miss = 1'b0;
        wait_done(0, cyc, seen);
        chk("second_done_seen", seen, 1'b1);
        @(negedge clk);
        chk("second_base_held", set_base_addr, 32'h0000_2000);
        chk("second_queues_empty", exp_req_q.size() + exp_wa_q.size() + exp_base_q.size(), 0);

        run_refill(32'hFFFF_FF00, 1'b1);

        // Asynchronous reset mid-refill
        push_refill(32'h0000_4000);
        @(negedge clk);
        i_cache_miss = 1'b1;
        miss_addr    = 32'h0000_4000;
        @(negedge clk);
        i_cache_miss = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        chk("busy_before_reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs, 166'd0);
        exp_req_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        exp_bound_q.delete();
        exp_base_q.delete();
        pend = 1'b0;
        wait_c = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", outs, 166'd0);

        run_refill(32'h0000_1234, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_cache_refill_ctrl.md
Name: i_cache_refill_ctrl

Overview:
- Refill controller at the cache-controller end of the I-cache refill interface.
- On a miss it invalidates the I-cache window and streams CACHE_WORDS words from backing memory into the slice over refill_enable/refill_address/refill_data.
- It then reprograms the base/bound window so fetches in the new region hit.
- One outstanding memory request; in-order responses.

Parameters:
- CACHE_WORDS, 256: words in the I-cache slice; power of two, ≥2. Window size in bytes is CACHE_WORDS*4.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_cache_miss  in  1  miss flag from the I-cache
- miss_addr  in  32  byte fetch address that missed
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  byte address of the requested word
- mem_rsp_valid  in  1  read data valid; one pulse per accepted request
- mem_rsp_data  in  32  read data
- refill_enable  out  1  slice write strobe
- refill_address  out  32  slice word index, 0..CACHE_WORDS-1, zero-extended
- refill_data  out  32  slice write data
- set_base_addr  out  32  new base value
- set_bound_addr  out  32  new bound value
- base_addr_we  out  1  base write strobe
- bound_addr_we  out  1  bound write strobe
- busy  out  1  high in every state except IDLE
- refill_done  out  1  one-cycle pulse when the window opens

Behaviour:
- All outputs are decoded from registered state and data only. There is no combinational input-to-output path.
- Reset: state IDLE; every output 0, including all strobes, addresses and data; word counter 0.
- Window: win_base = miss_addr & ~(CACHE_WORDS*4-1). win_bound = win_base + CACHE_WORDS*4 - 4 (inclusive). Both are latched in IDLE when i_cache_miss=1.
- IDLE: on i_cache_miss=1, latch the window, set idx = 0, go to INVAL.
- INVAL (1 cycle): base_addr_we=1, set_base_addr=32'hFFFF_FFFF so no fetch hits stale data. Go to REQ.
- REQ: mem_req_valid=1, mem_req_addr = win_base + 4*idx (32-bit wrap). On mem_req_ready=1, go to RESP. Otherwise hold valid and address stable.
- RESP: wait for mem_rsp_valid. On mem_rsp_valid=1, capture mem_rsp_data and go to WRITE. A mem_rsp_valid seen outside RESP is ignored.
- WRITE (1 cycle): refill_enable=1, refill_address=idx, refill_data=captured word.
  - If the word written is the last one, go to BOUND.
  - Otherwise increment idx (mod CACHE_WORDS) and go to REQ.
  - Counter width is $clog2(CACHE_WORDS). The count of words written is tracked separately, CACHE_WORDS of them in total.
- BOUND (1 cycle): bound_addr_we=1, set_bound_addr=win_bound. The window stays closed because base is still 0xFFFF_FFFF.
- BASE (1 cycle): base_addr_we=1, set_base_addr=win_base, refill_done=1. Go to IDLE.
- base_addr_we and bound_addr_we are never high together. The slice gives base priority, so the two writes are serialised.
- Minimum refill latency with zero-wait memory: 1 + 3*CACHE_WORDS + 2 cycles from leaving IDLE.
- i_cache_miss while busy is ignored. After returning to IDLE, a still-asserted miss, e.g. miss_addr outside the new window, starts a new refill next cycle.
- Strobes: idle-state data outputs hold their last values, but every strobe is 0.
- Reset mid-refill: immediate return to IDLE with all outputs 0. No partial window is written; the slice's own reset restores its window.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined: the initial idx = miss_addr[$clog2(CACHE_WORDS)+1:2]. idx wraps modulo CACHE_WORDS, and exactly CACHE_WORDS words are still fetched. Window and final writes are unchanged.
- Undefined: the initial idx is 0 and words are fetched in ascending order.

Test Plan:
- Reset, then hold idle: all outputs 0, busy=0. Assert rst_n mid-cycle: outputs clear with no clock edge.
- CACHE_WORDS=256, miss_addr=0x0000_1234, zero-wait memory returning data=addr:
  - First event is INVAL with set_base_addr=0xFFFF_FFFF.
  - Requests go to 0x1000..0x13FC; refill_address runs 0..255 with refill_data=0x1000+4*i.
  - Then bound_addr_we with 0x13FC, then base_addr_we with 0x1000 plus refill_done.
  - Total 771 cycles.
- mem_req_ready low for 5 cycles on word 3: mem_req_valid and mem_req_addr=0x100C stay stable. Random mem_rsp_valid delays do not change the data order.
- Second miss at 0x2000 asserted during the refill: ignored. After refill_done, a new refill starts with win_base=0x2000.
- miss_addr=0xFFFF_FF00 with CACHE_WORDS=256: win_base=0xFFFF_FC00 and win_bound=0xFFFF_FFFC; the last request address is 0xFFFF_FFFC.
- CRITICAL_WORD_FIRST_EN defined, miss_addr=0x1234: first refill_address=141 and first mem_req_addr=0x1234. Order wraps 255→0 and ends at 140; 256 writes total.
